// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, MISR taps, checker states and MISR step
package alu_pkg;
  localparam logic [2:0] ALU_FWD = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [7:0] MISR_TAPS = 8'b1011_1000;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [7:0] misr_next(input logic [7:0] s, input logic [7:0] d);
    return {s[6:0], ^(s & MISR_TAPS)} ^ d;
  endfunction
endpackage

// File: rtl/alu_ref_model.sv
// alu_ref_model: combinational golden ALU with reserved-opcode flag
module alu_ref_model import alu_pkg::*; (
  input  logic [2:0] aluop,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  output logic [7:0] exp_val,
  output logic       legal
);
  // expected result; reserved opcodes report illegal and a don't-care zero
  always_comb begin
    legal = !aluop[2];
    exp_val = aluop == ALU_FWD ? data2 :
              aluop == ALU_ADD ? data1 + data2 :
              aluop == ALU_AND ? data1 & data2 :
              aluop == ALU_OR  ? data1 | data2 : 8'h00;
  end
endmodule

// File: rtl/alu_result_checker.sv
// alu_result_checker: ALU output monitor with counts, first-fail capture and MISR
module alu_result_checker import alu_pkg::*; #(
  parameter logic [7:0] SIG_SEED = 8'hFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        valid,
  input  logic [7:0]  data1,
  input  logic [7:0]  data2,
  input  logic [2:0]  aluop,
  input  logic [7:0]  result,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic        illegal_op,
  output logic [15:0] vec_count,
  output logic [15:0] err_count,
  output logic [15:0] fail_idx,
  output logic [7:0]  fail_exp,
  output logic [7:0]  fail_got,
  output logic [7:0]  signature
);
  state_t state;
  logic [7:0] exp_val;
  logic legal, chk, bad, mis;
  logic [15:0] vec_n, err_n;
  alu_ref_model u_ref (.aluop(aluop), .data1(data1), .data2(data2), .exp_val(exp_val), .legal(legal));
  assign busy = state == RUN;
  assign done = state == DONE;
  // a vector counts only in RUN and never on a restart edge; counters saturate
  always_comb begin
    chk = state == RUN && valid && !start && legal;
    bad = state == RUN && valid && !start && !legal;
    mis = chk && result != exp_val;
    vec_n = (chk && vec_count != 16'hFFFF) ? vec_count + 16'd1 : vec_count;
    err_n = (mis && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
  end
  // run control, counters, first-fail capture, MISR and verdict
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      pass <= 1'b0;
      illegal_op <= 1'b0;
      vec_count <= 16'h0;
      err_count <= 16'h0;
      fail_idx <= 16'h0;
      fail_exp <= 8'h0;
      fail_got <= 8'h0;
      signature <= SIG_SEED;
    end else if (start) begin
      state <= RUN;
      pass <= 1'b0;
      illegal_op <= 1'b0;
      vec_count <= 16'h0;
      err_count <= 16'h0;
      fail_idx <= 16'h0;
      fail_exp <= 8'h0;
      fail_got <= 8'h0;
      signature <= SIG_SEED;
    end else begin
      vec_count <= vec_n;
      err_count <= err_n;
      illegal_op <= illegal_op | bad;
      if (mis && err_count == 16'h0) begin
        fail_idx <= vec_count;
        fail_exp <= exp_val;
        fail_got <= result;
      end
      if (chk) signature <= misr_next(signature, result);
      if (state == RUN && stop) begin
        state <= DONE;
        pass <= err_n == 16'h0 && !(illegal_op | bad) && vec_n != 16'h0;
      end
    end
  end
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed and random checks against a behavioural model
module tb_alu_result_checker;
  logic clk = 1'b0, reset = 1'b0, start = 1'b0, stop = 1'b0, valid = 1'b0;
  logic [7:0] data1 = 8'h0, data2 = 8'h0, result = 8'h0;
  logic [2:0] aluop = 3'h0;
  logic busy, done, pass, illegal_op;
  logic [15:0] vec_count, err_count, fail_idx;
  logic [7:0] fail_exp, fail_got, signature;
  int checks = 0, errors = 0;
  int m_st = 0;
  logic [15:0] m_vec = 0, m_err = 0, m_fidx = 0;
  logic [7:0] m_fexp = 0, m_fgot = 0, m_sig = 8'hFF;
  bit m_ill = 0;

  alu_result_checker #(.SIG_SEED(8'hFF)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .valid(valid),
    .data1(data1), .data2(data2), .aluop(aluop), .result(result),
    .busy(busy), .done(done), .pass(pass), .illegal_op(illegal_op),
    .vec_count(vec_count), .err_count(err_count), .fail_idx(fail_idx),
    .fail_exp(fail_exp), .fail_got(fail_got), .signature(signature)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] gold(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int s;
    case (op)
      3'd1: s = (int'(a) + int'(b)) % 256;
      3'd2: s = int'(a & b);
      3'd3: s = int'(a | b);
      default: s = int'(b);
    endcase
    return 8'(s);
  endfunction

  function automatic logic [7:0] tb_misr(input logic [7:0] s, input logic [7:0] r);
    int fb, nx;
    fb = ((s >> 7) ^ (s >> 5) ^ (s >> 4) ^ (s >> 3)) & 1;
    nx = ((int'(s) * 2) % 256) + fb;
    return 8'(nx) ^ r;
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_all();
    chk("busy", 16'(busy), 16'(m_st == 1));
    chk("done", 16'(done), 16'(m_st == 2));
    chk("pass", 16'(pass), 16'(m_st == 2 && m_err == 0 && !m_ill && m_vec != 0));
    chk("illegal_op", 16'(illegal_op), 16'(m_ill));
    chk("vec_count", vec_count, m_vec);
    chk("err_count", err_count, m_err);
    chk("fail_idx", fail_idx, m_fidx);
    chk("fail_exp", 16'(fail_exp), 16'(m_fexp));
    chk("fail_got", 16'(fail_got), 16'(m_fgot));
    chk("signature", 16'(signature), 16'(m_sig));
  endtask

  task automatic model(input bit rn, input bit st, input bit sp, input bit v,
                       input logic [2:0] op, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] r);
    logic [7:0] e;
    if (!rn || st) begin
      m_st = rn ? 1 : 0;
      m_vec = 0; m_err = 0; m_fidx = 0; m_fexp = 0; m_fgot = 0; m_sig = 8'hFF; m_ill = 0;
    end else if (m_st == 1) begin
      if (v && op < 4) begin
        e = gold(op, d1, d2);
        if (r != e) begin
          if (m_err == 0) begin m_fidx = m_vec; m_fexp = e; m_fgot = r; end
          if (m_err != 16'hFFFF) m_err++;
        end
        if (m_vec != 16'hFFFF) m_vec++;
        m_sig = tb_misr(m_sig, r);
      end else if (v) m_ill = 1;
      if (sp) m_st = 2;
    end
  endtask

  task automatic step(input bit rn, input bit st, input bit sp, input bit v, input logic [2:0] op,
                      input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] r, input bit ck);
    reset = rn; start = st; stop = sp; valid = v; aluop = op; data1 = d1; data2 = d2; result = r;
    @(posedge clk);
    model(rn, st, sp, v, op, d1, d2, r);
    #1;
    if (ck) check_all();
  endtask

  task automatic vec(input logic [2:0] op, input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] r);
    step(1, 0, 0, 1, op, d1, d2, r, 1);
  endtask

  task automatic idle(input bit st, input bit sp);
    step(1, st, sp, 0, 3'd0, 8'h0, 8'h0, 8'h0, 1);
  endtask

  initial begin
    step(0, 0, 0, 0, 3'd0, 8'h0, 8'h0, 8'h0, 1);
    chk("rst_sig", 16'(signature), 16'hFF);
    chk("rst_vec", vec_count, 16'h0);
    step(1, 0, 0, 1, 3'd1, 8'h1, 8'h2, 8'h3, 1);
    chk("idle_ignore", vec_count, 16'h0);

    idle(1, 0);
    chk("start_busy", 16'(busy), 16'h1);
    vec(3'd3, 8'd25, 8'd3, 8'd27);
    vec(3'd3, 8'd1, 8'd8, 8'd9);
    vec(3'd3, 8'd2, 8'hFB, 8'hFB);
    vec(3'd3, 8'd6, 8'hFE, 8'hFE);
    idle(0, 1);
    chk("or_vec", vec_count, 16'd4);
    chk("or_err", err_count, 16'd0);
    chk("or_pass", 16'(pass), 16'h1);
    step(1, 0, 0, 1, 3'd1, 8'h1, 8'h1, 8'h7, 1);
    chk("done_ignore", vec_count, 16'd4);

    idle(1, 0);
    vec(3'd1, 8'd127, 8'd1, 8'h80);
    vec(3'd2, 8'hF0, 8'h3C, 8'h00);
    idle(0, 1);
    chk("fail_err", err_count, 16'd1);
    chk("fail_idx", fail_idx, 16'd1);
    chk("fail_exp", 16'(fail_exp), 16'h30);
    chk("fail_got", 16'(fail_got), 16'h00);
    chk("fail_pass", 16'(pass), 16'h0);

    step(1, 1, 0, 1, 3'd0, 8'h0, 8'h0, 8'h55, 1);
    chk("start_edge_skip", vec_count, 16'd0);
    vec(3'd0, 8'h0, 8'h00, 8'h00);
    chk("misr_1", 16'(signature), 16'hFE);
    vec(3'd0, 8'h0, 8'h00, 8'h00);
    chk("misr_2", 16'(signature), 16'hFC);

    idle(1, 0);
    vec(3'd2, 8'h0F, 8'hFF, 8'h0F);
    vec(3'b101, 8'h1, 8'h2, 8'h3);
    chk("ill_flag", 16'(illegal_op), 16'h1);
    chk("ill_vec", vec_count, 16'd1);
    idle(0, 1);
    chk("ill_pass", 16'(pass), 16'h0);

    idle(1, 0);
    vec(3'd1, 8'h10, 8'h20, 8'h30);
    step(1, 0, 1, 1, 3'd1, 8'h01, 8'h02, 8'h03, 1);
    chk("stop_vec", vec_count, 16'd2);
    chk("stop_done", 16'(done), 16'h1);
    chk("stop_pass", 16'(pass), 16'h1);
    idle(1, 1);
    chk("restart_busy", 16'(busy), 16'h1);
    chk("restart_vec", vec_count, 16'd0);

    vec(3'd3, 8'h1, 8'h2, 8'h3);
    vec(3'd3, 8'h1, 8'h2, 8'h3);
    vec(3'd3, 8'h1, 8'h2, 8'h3);
    step(0, 0, 0, 1, 3'd3, 8'h1, 8'h2, 8'h3, 1);
    chk("rst_busy", 16'(busy), 16'h0);
    chk("rst_vec2", vec_count, 16'd0);
    chk("rst_sig2", 16'(signature), 16'hFF);
    vec(3'd3, 8'h1, 8'h2, 8'h3);
    chk("rst_idle_ignore", vec_count, 16'd0);

    idle(1, 0);
    for (int i = 0; i < 65540; i++) begin
      logic [7:0] d;
      d = 8'($urandom);
      step(1, 0, 0, 1, 3'd0, 8'h0, d, ~d, 0);
    end
    check_all();
    chk("sat_vec", vec_count, 16'hFFFF);
    chk("sat_err", err_count, 16'hFFFF);
    chk("sat_idx", fail_idx, 16'h0);
    idle(0, 1);

    for (int i = 0; i < 600; i++) begin
      logic [2:0] op;
      logic [7:0] a, b, r;
      bit rn, st, sp, v;
      rn = $urandom_range(0, 99) != 0;
      st = $urandom_range(0, 39) == 0;
      sp = $urandom_range(0, 29) == 0;
      v = $urandom_range(0, 3) != 0;
      op = $urandom_range(0, 15) == 0 ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      a = 8'($urandom);
      b = 8'($urandom);
      r = $urandom_range(0, 5) == 0 ? 8'($urandom) : gold(op, a, b);
      step(rn, st, sp, v, op, a, b, r, 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_result_checker.md
# alu_result_checker

Sequential self-checking monitor for the 8-bit ALU: it sits on the ALU's output side, alongside the unit under test, and consumes the same operand/opcode/result traffic the stimulus side drives. Each qualified vector is compared against an internal golden model, with error count, first-failure capture and a MISR signature of all results. It turns directed ALU benches and on-chip self-test runs into a single PASS bit plus diagnostics.

## Interface
- SIG_SEED, 8'hFF: MISR value loaded on START.
- CLK  in  1  rising-edge clock.
- RESET  in  1  synchronous, active-low; sampled on CLK rising edge.
- START  in  1  one-cycle pulse; clears run state and enters RUN.
- STOP  in  1  one-cycle pulse; ends run and enters DONE.
- VALID  in  1  qualifies DATA1/DATA2/ALUOP/RESULT this cycle.
- DATA1  in  8  operand 1 (two's complement).
- DATA2  in  8  operand 2 (two's complement).
- ALUOP  in  3  ALU select: 000 FORWARD (DATA2), 001 ADD, 010 AND, 011 OR, 1xx reserved.
- RESULT  in  8  ALU output under test.
- BUSY  out  1  high in RUN.
- DONE  out  1  high in DONE.
- PASS  out  1  DONE && ERR_COUNT==0 && !ILLEGAL_OP && VEC_COUNT!=0.
- ILLEGAL_OP  out  1  sticky; a reserved ALUOP arrived with VALID in RUN.
- VEC_COUNT  out  16  checked vectors, saturating at 16'hFFFF.
- ERR_COUNT  out  16  mismatches, saturating at 16'hFFFF.
- FAIL_IDX  out  16  VEC_COUNT value of first mismatch.
- FAIL_EXP  out  8  expected value of first mismatch.
- FAIL_GOT  out  8  RESULT of first mismatch.
- SIGNATURE  out  8  MISR state.

## Operation
- States: IDLE → (START) RUN → (STOP) DONE → (START) RUN. Reset → IDLE.
- Priority: RESET > START > STOP. START in RUN or DONE restarts: counters, FAIL_*, ILLEGAL_OP cleared, SIGNATURE = SIG_SEED.
- In RUN with VALID and legal ALUOP: EXP = golden(ALUOP, DATA1, DATA2); ADD is 8-bit wrap, carry discarded; mismatch if RESULT != EXP.
- Per legal vector: VEC_COUNT+1; on mismatch ERR_COUNT+1; on first mismatch (ERR_COUNT==0) latch FAIL_IDX = pre-increment VEC_COUNT, FAIL_EXP, FAIL_GOT.
- MISR per legal vector: fb = S[7]^S[5]^S[4]^S[3]; S <= {S[6:0],fb} ^ RESULT.
- Reserved ALUOP with VALID: sets ILLEGAL_OP; no count, no compare, no MISR update.
- VALID ignored in IDLE and DONE; STOP ignored outside RUN.
- Saturation: counters hold at FFFF; compare, capture and MISR continue.

## Timing
- Reset values: BUSY 0, DONE 0, PASS 0, ILLEGAL_OP 0, VEC_COUNT 0, ERR_COUNT 0, FAIL_IDX 0, FAIL_EXP 0, FAIL_GOT 0, SIGNATURE SIG_SEED.
- Inputs sampled at the edge; all outputs registered, visible one cycle after the sampled vector.
- START at edge n: BUSY=1 after n; a VALID vector at edge n is not checked (first checkable at n+1).
- STOP with VALID at the same edge: that vector is checked, then DONE=1, PASS valid the same cycle.
- Reset mid-run: all outputs to reset values at that edge, state IDLE.
- No stall: one vector per cycle, back-to-back VALID supported.

## Structure
- Shared package alu_pkg: ALUOP encodings (ALU_FWD, ALU_ADD, ALU_AND, ALU_OR), MISR tap constant, state enum {IDLE, RUN, DONE}.
- Sub-module alu_ref_model: combinational golden model (ALUOP, DATA1, DATA2 → EXP, LEGAL), reusable by benches.
- Top holds FSM, counters, first-fail capture, MISR.

## Test plan
- START; OR vectors 25|3→27, 1|8→9, 2|-5→FB, 6|-2→FE all correct; STOP → VEC_COUNT 4, ERR_COUNT 0, PASS 1.
- ADD 127+1 with RESULT 8'h80, then AND 8'hF0&8'h3C with RESULT 8'h00 (exp 8'h30) → ERR_COUNT 1, FAIL_IDX 1, FAIL_EXP 30, FAIL_GOT 00, PASS 0.
- Seed FF, single FORWARD DATA2=00, RESULT 00 → SIGNATURE FE; same vector repeated → SIGNATURE FC.
- ALUOP 3'b101 with VALID mid-run → ILLEGAL_OP 1, VEC_COUNT unchanged, PASS 0 after STOP.
- STOP with VALID same edge → vector counted, DONE next cycle; START+STOP same edge in DONE → RUN, counters cleared.
- RESET low mid-run after 3 vectors → all outputs reset values next cycle, VALID ignored until START.
